// File: rtl/clk_div_pkg.sv
// Shared definitions for the ref-clock divider configuration sequencer.
//   state_t          : sequencer FSM encoding
//   DEF_RATIO        : ratio driven out of reset
//   MIN_LEGAL_RATIO  : smallest ratio the divider can actually divide by
package clk_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QUIET  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  localparam int DEF_RATIO       = 2;
  localparam int MIN_LEGAL_RATIO = 2;

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Client-side request bus of the divider configuration sequencer.
//   req      : level request per client, [0] = A (reg file), [1] = B (UART prescale)
//   ratio_a  : ratio requested by A, stable while req[0] is high
//   ratio_b  : ratio requested by B, stable while req[1] is high
//   ack      : one-cycle completion pulse to the granted client
//   err      : one-cycle pulse with ack when the requested ratio was illegal
// master = client side, slave = sequencer side.
interface clk_div_cfg_ctrl_if #(
  parameter int RATIO_WD = 4
);

  logic [1:0]          req;
  logic [RATIO_WD-1:0] ratio_a;
  logic [RATIO_WD-1:0] ratio_b;
  logic [1:0]          ack;
  logic                err;

  modport master (output req, output ratio_a, output ratio_b, input ack, input err);
  modport slave  (input req, input ratio_a, input ratio_b, output ack, output err);

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the requests;
// the priority pointer moves only when the grant is accepted.
//   i_ref_clk : clock
//   i_rst_n   : synchronous active-low reset (pointer favours client 0)
//   i_req     : request vector
//   i_accept  : grant consumed this cycle
//   o_gnt     : one-hot grant (zero when no request)
module rr_arb2 (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // 1 = client 1 wins the next tie
  logic prio_b;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = prio_b ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      prio_b <= 1'b0;
    end else if (i_accept) begin
      // whoever did not just win gets the next tie
      prio_b <= o_gnt[0];
    end
  end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Sequencer owning the ratio/enable inputs of the ref-clock divider.
// Arbitrates ratio changes from two clients and applies each one glitch-safely:
// divider off, quiet gap, load, re-enable, settle, ack.
//   i_ref_clk   : reference clock, single clock of this block
//   i_rst_n     : synchronous active-low reset
//   cfg         : client request bus (slave side)
//   o_div_ratio : registered ratio to the divider
//   o_clk_en    : registered divider enable, 0 = bypass to ref clock
//   o_busy      : high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner
// QUIET  | divider held disabled for QUIET_CYC cycles
// LOAD   | new ratio driven, enable restored if the ratio is legal
// SETTLE | SETTLE_CYC cycles for the divider to settle
// ACK    | one-cycle ack (and err if illegal) to the winner
module clk_div_cfg_ctrl #(
  parameter int RATIO_WD   = 4,
  parameter int DEF_RATIO  = clk_div_pkg::DEF_RATIO,
  parameter int QUIET_CYC  = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  clk_div_cfg_ctrl_if.slave   cfg,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_clk_en,
  output logic                o_busy
);

  import clk_div_pkg::*;

  localparam int CNT_MAX = (QUIET_CYC > SETTLE_CYC) ? QUIET_CYC : SETTLE_CYC;
  localparam int CNT_WD  = $clog2(CNT_MAX + 1);
  localparam logic [CNT_WD-1:0] QUIET_LD  = CNT_WD'(QUIET_CYC - 1);
  localparam logic [CNT_WD-1:0] SETTLE_LD = CNT_WD'(SETTLE_CYC - 1);

  state_t              state;
  state_t              next_state;
  logic [CNT_WD-1:0]   cnt;

  logic [1:0]          gnt;
  logic                accept;
  logic                gnt_id;
  logic [RATIO_WD-1:0] gnt_ratio;
  logic                gnt_legal;
  logic                fast_hit;

  logic                win_q;
  logic [RATIO_WD-1:0] ratio_q;
  logic                legal_q;

  logic [1:0]          ack_q;
  logic                err_q;
  logic [1:0]          ack_d;
  logic                err_d;
  logic [RATIO_WD-1:0] ratio_d;
  logic                en_d;
  logic                busy_d;
  logic                sel_id;
  logic                sel_legal;

  rr_arb2 u_arb (
    .i_ref_clk (i_ref_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (cfg.req),
    .i_accept  (accept),
    .o_gnt     (gnt)
  );

  assign accept    = (state == ST_IDLE) && (|gnt);
  assign gnt_id    = gnt[1];
  assign gnt_ratio = gnt_id ? cfg.ratio_b : cfg.ratio_a;
  assign gnt_legal = (gnt_ratio >= RATIO_WD'(MIN_LEGAL_RATIO));
  // ratio already in place: skip the disable/reload sequence entirely
  assign fast_hit  = gnt_legal && (gnt_ratio == o_div_ratio);

  assign cfg.ack = ack_q;
  assign cfg.err = err_q;

  // state register plus the registered datapath it steers
  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      win_q       <= 1'b0;
      ratio_q     <= RATIO_WD'(DEF_RATIO);
      legal_q     <= 1'b1;
      ack_q       <= 2'b00;
      err_q       <= 1'b0;
      o_div_ratio <= RATIO_WD'(DEF_RATIO);
      o_clk_en    <= 1'b1;
      o_busy      <= 1'b0;
    end else begin
      state       <= next_state;
      ack_q       <= ack_d;
      err_q       <= err_d;
      o_div_ratio <= ratio_d;
      o_clk_en    <= en_d;
      o_busy      <= busy_d;

      if (accept) begin
        win_q   <= gnt_id;
        ratio_q <= gnt_ratio;
        legal_q <= gnt_legal;
      end

      // down-counter preloaded on entry to each timed phase, holds at zero
      if (state == ST_IDLE) begin
        cnt <= QUIET_LD;
      end else if (state == ST_LOAD) begin
        cnt <= SETTLE_LD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_WD'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = fast_hit ? ST_ACK : ST_QUIET;
      ST_QUIET:  if (cnt == '0) next_state = ST_LOAD;
      ST_LOAD:   next_state = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) next_state = ST_ACK;
      ST_ACK:    next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    ack_d   = 2'b00;
    err_d   = 1'b0;
    ratio_d = o_div_ratio;
    en_d    = o_clk_en;
    busy_d  = (next_state != ST_IDLE);

    // on the fast path the winner has not been latched yet
    sel_id    = (state == ST_IDLE) ? gnt_id    : win_q;
    sel_legal = (state == ST_IDLE) ? gnt_legal : legal_q;

    if (next_state == ST_ACK) begin
      ack_d[sel_id] = 1'b1;
      err_d         = ~sel_legal;
    end

    if ((state == ST_IDLE) && (next_state == ST_QUIET)) begin
      en_d = 1'b0;
    end

    // illegal ratios are still loaded but the divider stays in bypass
    if (state == ST_LOAD) begin
      ratio_d = ratio_q;
      en_d    = legal_q;
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
module tb_clk_div_cfg_ctrl;

  localparam int RW = 4;

  logic          i_ref_clk = 1'b0;
  logic          i_rst_n;
  logic [RW-1:0] o_div_ratio;
  logic          o_clk_en;
  logic          o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  // per-cycle record, index k = values seen just after edge Ek
  logic [1:0]    ack_log   [0:31];
  logic          err_log   [0:31];
  logic          en_log    [0:31];
  logic          busy_log  [0:31];
  logic [RW-1:0] ratio_log [0:31];

  clk_div_cfg_ctrl_if #(.RATIO_WD(RW)) bus ();

  clk_div_cfg_ctrl #(
    .RATIO_WD   (RW),
    .DEF_RATIO  (2),
    .QUIET_CYC  (2),
    .SETTLE_CYC (4)
  ) dut (
    .i_ref_clk   (i_ref_clk),
    .i_rst_n     (i_rst_n),
    .cfg         (bus),
    .o_div_ratio (o_div_ratio),
    .o_clk_en    (o_clk_en),
    .o_busy      (o_busy)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    i_rst_n     = 1'b0;
    bus.req     = 2'b00;
    bus.ratio_a = '0;
    bus.ratio_b = '0;
    @(posedge i_ref_clk);
    @(posedge i_ref_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Runs n edges (E0 first). Clients drop their request one edge after
  // their ack is visible; drop_k forces A to drop early at cycle k.
  task automatic run(input int n, input int drop_k);
    logic [1:0] pend;
    pend = 2'b00;
    for (int k = 0; k < n; k++) begin
      @(posedge i_ref_clk);
      #1;
      bus.req = bus.req & ~pend;
      if (k == drop_k) bus.req[0] = 1'b0;
      ack_log[k]   = bus.ack;
      err_log[k]   = bus.err;
      en_log[k]    = o_clk_en;
      busy_log[k]  = o_busy;
      ratio_log[k] = o_div_ratio;
      pend = bus.ack;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (o_div_ratio !== 4'd2) begin n_fail++; $display("FAIL rst_ratio got=%0d exp=2", o_div_ratio); end
    n_tests++; if (o_clk_en !== 1'b1) begin n_fail++; $display("FAIL rst_en got=%b exp=1", o_clk_en); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    n_tests++; if (bus.ack !== 2'b00 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b/%b exp=00/0", bus.ack, bus.err); end
    // start a change and reset it while in SETTLE
    bus.ratio_a = 4'd6;
    bus.req     = 2'b01;
    repeat (5) @(posedge i_ref_clk);
    #1;
    n_tests++; if (o_busy !== 1'b1 || o_div_ratio !== 4'd6) begin n_fail++; $display("FAIL settle_pre got busy=%b ratio=%0d exp busy=1 ratio=6", o_busy, o_div_ratio); end
    i_rst_n = 1'b0;
    bus.req = 2'b00;
    @(posedge i_ref_clk);
    #1;
    n_tests++; if (o_div_ratio !== 4'd2) begin n_fail++; $display("FAIL midrst_ratio got=%0d exp=2", o_div_ratio); end
    n_tests++; if (o_clk_en !== 1'b1) begin n_fail++; $display("FAIL midrst_en got=%b exp=1", o_clk_en); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
    n_tests++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL midrst_ack got=%b exp=00", bus.ack); end
    i_rst_n = 1'b1;
  endtask

  task automatic test_full_a();
    bus.ratio_a = 4'd6;
    bus.req     = 2'b01;
    run(12, -1);
    for (int k = 0; k < 12; k++) begin
      n_tests++; if (en_log[k] !== (k >= 3)) begin n_fail++; $display("FAIL full_en k=%0d got=%b exp=%b", k, en_log[k], (k >= 3)); end
      n_tests++; if (ratio_log[k] !== ((k >= 3) ? 4'd6 : 4'd2)) begin n_fail++; $display("FAIL full_ratio k=%0d got=%0d", k, ratio_log[k]); end
      n_tests++; if (ack_log[k] !== ((k == 7) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL full_ack k=%0d got=%b", k, ack_log[k]); end
      n_tests++; if (err_log[k] !== 1'b0) begin n_fail++; $display("FAIL full_err k=%0d got=%b exp=0", k, err_log[k]); end
      n_tests++; if (busy_log[k] !== (k <= 7)) begin n_fail++; $display("FAIL full_busy k=%0d got=%b exp=%b", k, busy_log[k], (k <= 7)); end
    end
  endtask

  task automatic test_tie();
    logic [1:0]    exp_ack;
    logic [RW-1:0] exp_ratio;
    logic          exp_en;
    logic          exp_busy;
    apply_reset();
    bus.ratio_a = 4'd4;
    bus.ratio_b = 4'd8;
    bus.req     = 2'b11;
    run(20, -1);
    for (int k = 0; k < 20; k++) begin
      exp_ack   = (k == 7) ? 2'b01 : ((k == 16) ? 2'b10 : 2'b00);
      exp_ratio = (k < 3) ? 4'd2 : ((k < 12) ? 4'd4 : 4'd8);
      exp_en    = !((k <= 2) || (k >= 9 && k <= 11));
      exp_busy  = (k <= 7) || (k >= 9 && k <= 16);
      n_tests++; if (ack_log[k] !== exp_ack) begin n_fail++; $display("FAIL tie_ack k=%0d got=%b exp=%b", k, ack_log[k], exp_ack); end
      n_tests++; if (ratio_log[k] !== exp_ratio) begin n_fail++; $display("FAIL tie_ratio k=%0d got=%0d exp=%0d", k, ratio_log[k], exp_ratio); end
      n_tests++; if (en_log[k] !== exp_en) begin n_fail++; $display("FAIL tie_en k=%0d got=%b exp=%b", k, en_log[k], exp_en); end
      n_tests++; if (busy_log[k] !== exp_busy) begin n_fail++; $display("FAIL tie_busy k=%0d got=%b exp=%b", k, busy_log[k], exp_busy); end
    end
    // pointer now favours A again
    bus.ratio_a = 4'd5;
    bus.ratio_b = 4'd9;
    bus.req     = 2'b11;
    run(8, -1);
    n_tests++; if (ack_log[7] !== 2'b01) begin n_fail++; $display("FAIL tie2_ack got=%b exp=01", ack_log[7]); end
    n_tests++; if (ratio_log[7] !== 4'd5) begin n_fail++; $display("FAIL tie2_ratio got=%0d exp=5", ratio_log[7]); end
  endtask

  task automatic test_fast_b();
    apply_reset();
    bus.ratio_b = 4'd2;
    bus.req     = 2'b10;
    run(6, -1);
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (ack_log[k] !== ((k == 0) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL fast_ack k=%0d got=%b", k, ack_log[k]); end
      n_tests++; if (en_log[k] !== 1'b1) begin n_fail++; $display("FAIL fast_en k=%0d got=%b exp=1", k, en_log[k]); end
      n_tests++; if (busy_log[k] !== (k == 0)) begin n_fail++; $display("FAIL fast_busy k=%0d got=%b exp=%b", k, busy_log[k], (k == 0)); end
      n_tests++; if (ratio_log[k] !== 4'd2 || err_log[k] !== 1'b0) begin n_fail++; $display("FAIL fast_ratio k=%0d got=%0d/%b exp=2/0", k, ratio_log[k], err_log[k]); end
    end
  endtask

  task automatic test_illegal();
    bus.ratio_a = 4'd1;
    bus.req     = 2'b01;
    run(10, -1);
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (en_log[k] !== 1'b0) begin n_fail++; $display("FAIL ill_en k=%0d got=%b exp=0", k, en_log[k]); end
      n_tests++; if (ratio_log[k] !== ((k >= 3) ? 4'd1 : 4'd2)) begin n_fail++; $display("FAIL ill_ratio k=%0d got=%0d", k, ratio_log[k]); end
      n_tests++; if (ack_log[k] !== ((k == 7) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL ill_ack k=%0d got=%b", k, ack_log[k]); end
      n_tests++; if (err_log[k] !== (k == 7)) begin n_fail++; $display("FAIL ill_err k=%0d got=%b exp=%b", k, err_log[k], (k == 7)); end
    end
    bus.ratio_a = 4'd3;
    bus.req     = 2'b01;
    run(10, -1);
    for (int k = 0; k < 10; k++) begin
      n_tests++; if (en_log[k] !== (k >= 3)) begin n_fail++; $display("FAIL rec_en k=%0d got=%b exp=%b", k, en_log[k], (k >= 3)); end
      n_tests++; if (ratio_log[k] !== ((k >= 3) ? 4'd3 : 4'd1)) begin n_fail++; $display("FAIL rec_ratio k=%0d got=%0d", k, ratio_log[k]); end
      n_tests++; if (ack_log[k] !== ((k == 7) ? 2'b01 : 2'b00) || err_log[k] !== 1'b0) begin n_fail++; $display("FAIL rec_ack k=%0d got=%b/%b", k, ack_log[k], err_log[k]); end
    end
  endtask

  task automatic test_drop_mid();
    bus.ratio_a = 4'd6;
    bus.req     = 2'b01;
    run(12, 1);
    for (int k = 0; k < 12; k++) begin
      n_tests++; if (ack_log[k] !== ((k == 7) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL drop_ack k=%0d got=%b", k, ack_log[k]); end
      n_tests++; if (ratio_log[k] !== ((k >= 3) ? 4'd6 : 4'd3)) begin n_fail++; $display("FAIL drop_ratio k=%0d got=%0d", k, ratio_log[k]); end
      n_tests++; if (en_log[k] !== (k >= 3)) begin n_fail++; $display("FAIL drop_en k=%0d got=%b exp=%b", k, en_log[k], (k >= 3)); end
      n_tests++; if (busy_log[k] !== (k <= 7)) begin n_fail++; $display("FAIL drop_busy k=%0d got=%b exp=%b", k, busy_log[k], (k <= 7)); end
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    bus.req     = 2'b00;
    bus.ratio_a = '0;
    bus.ratio_b = '0;
    test_reset();
    test_full_a();
    test_tie();
    test_fast_b();
    test_illegal();
    test_drop_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
